// File: rtl/adder_acc_pkg.sv
// adder_acc_pkg: FSM state encoding and the o_count width helper shared by the accumulator and its interface.
package adder_acc_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;
  function automatic int cnt_w(input int num_acc);
    return $clog2(num_acc + 1);
  endfunction
endpackage

// File: rtl/adder_acc_if.sv
// adder_acc_if: adder-result input handshake plus accumulated-result output handshake.
interface adder_acc_if
  import adder_acc_pkg::*;
#(
  parameter int BW_DATA = 6,
  parameter int NUM_ACC = 4,
  parameter int BW_ACC  = 8
);
  localparam int BW_CNT = cnt_w(NUM_ACC);
  logic [BW_DATA-1:0] i_sum;
  logic               i_cout;
  logic               i_valid;
  logic               o_ready;
  logic               i_clear;
  logic [BW_ACC-1:0]  o_acc;
  logic               o_ovf;
  logic [BW_CNT-1:0]  o_count;
  logic               o_valid;
  logic               i_ready;
  modport master (
    output i_sum, i_cout, i_valid, i_clear, i_ready,
    input  o_ready, o_acc, o_ovf, o_count, o_valid
  );
  modport slave (
    input  i_sum, i_cout, i_valid, i_clear, i_ready,
    output o_ready, o_acc, o_ovf, o_count, o_valid
  );
endinterface

// File: rtl/adder_acc.sv
// adder_acc: sums NUM_ACC upstream {cout,sum} words and offers the total on a valid/ready output.
// ADDER_ACC_SAT_EN makes the accumulator saturate on carry instead of wrapping with sticky overflow.
module adder_acc
  import adder_acc_pkg::*;
#(
  parameter int BW_DATA = 6,
  parameter int NUM_ACC = 4,
  parameter int BW_ACC  = 8
) (
  input logic        i_clk,
  input logic        i_rstn,
  adder_acc_if.slave bus
);
  localparam int BW_CNT = cnt_w(NUM_ACC);
  state_t            state_q;
  logic [BW_ACC-1:0] acc_q, acc_d, base, w;
  logic [BW_ACC:0]   sum_w;
  logic [BW_CNT-1:0] cnt_q, cnt_d;
  logic              ovf_q, ovf_d, valid_q, take, last;
  assign take = bus.i_valid && bus.o_ready;
  assign last = cnt_d == BW_CNT'(NUM_ACC);
  // IDLE starts a fresh batch, so the stale accumulator never enters the add
  always_comb begin
    base  = (state_q == IDLE) ? '0 : acc_q;
    w     = BW_ACC'({bus.i_cout, bus.i_sum});
    sum_w = {1'b0, base} + {1'b0, w};
`ifdef ADDER_ACC_SAT_EN
    acc_d = sum_w[BW_ACC] ? '1 : sum_w[BW_ACC-1:0];
`else
    acc_d = sum_w[BW_ACC-1:0];
`endif
    ovf_d = (state_q != IDLE && ovf_q) || sum_w[BW_ACC];
    cnt_d = cnt_q + BW_CNT'(1);
  end
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (bus.i_clear || (state_q == DONE && bus.i_ready)) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (take) begin
      state_q <= last ? DONE : ACC;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      valid_q <= last;
    end
  assign bus.o_ready = state_q != DONE;
  assign bus.o_valid = valid_q;
  assign bus.o_acc   = acc_q;
  assign bus.o_ovf   = ovf_q;
  assign bus.o_count = cnt_q;
endmodule

// File: tb/tb_adder_acc.sv
// tb_adder_acc: directed and random batches; expected results are queued at stimulus time and checked by a monitor.
module tb_adder_acc;
  typedef struct {
    logic [7:0] acc;
    logic       ovf;
    logic [2:0] cnt;
  } exp_t;
`ifdef ADDER_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic rnd = 1'b0;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  adder_acc_if #(.BW_DATA(6), .NUM_ACC(4), .BW_ACC(8)) bus ();
  adder_acc #(.BW_DATA(6), .NUM_ACC(4), .BW_ACC(8)) dut (
    .i_clk (clk),
    .i_rstn(rstn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [5:0] s, input logic c);
    logic r;
    bus.i_sum   = s;
    bus.i_cout  = c;
    bus.i_valid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      r = bus.o_ready;
      @(posedge clk);
      #1;
      if (r) begin
        bus.i_valid = 1'b0;
        return;
      end
    end
    chk("send_timeout", 0, 1);
    bus.i_valid = 1'b0;
  endtask

  initial forever begin
    @(negedge clk);
    if (bus.o_valid) begin
      if (sb.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        chk("sb_acc", int'(bus.o_acc), int'(sb[0].acc));
        chk("sb_ovf", int'(bus.o_ovf), int'(sb[0].ovf));
        chk("sb_count", int'(bus.o_count), int'(sb[0].cnt));
        if (bus.i_ready) void'(sb.pop_front());
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd) bus.i_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    bus.i_sum   = '0;
    bus.i_cout  = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_clear = 1'b0;
    bus.i_ready = 1'b1;
    #1 rstn = 1'b0;
    idle(2);
    chk("rst_acc", int'(bus.o_acc), 0);
    chk("rst_ovf", int'(bus.o_ovf), 0);
    chk("rst_count", int'(bus.o_count), 0);
    chk("rst_valid", int'(bus.o_valid), 0);
    chk("rst_ready", int'(bus.o_ready), 1);
    rstn = 1'b1;
    idle(1);

    sb.push_back('{8'd40, 1'b0, 3'd4});
    repeat (4) send(6'd10, 1'b0);
    chk("basic_latency", int'(bus.o_valid), 1);
    idle(1);
    chk("basic_release", int'(bus.o_valid), 0);

    sb.push_back('{SAT ? 8'd255 : 8'd252, 1'b1, 3'd4});
    repeat (4) send(6'd63, 1'b1);
    idle(1);

    bus.i_ready = 1'b0;
    sb.push_back('{8'd10, 1'b0, 3'd4});
    for (int k = 1; k <= 4; k++) begin
      send(6'(k), 1'b0);
      if (k < 4) idle(2);
    end
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("bp_ready", int'(bus.o_ready), 0);
      chk("bp_acc", int'(bus.o_acc), 10);
      @(posedge clk);
      #1;
    end
    bus.i_ready = 1'b1;
    idle(1);
    chk("bp_idle_valid", int'(bus.o_valid), 0);
    chk("bp_idle_ready", int'(bus.o_ready), 1);

    send(6'd5, 1'b0);
    send(6'd6, 1'b0);
    chk("pre_clr_count", int'(bus.o_count), 2);
    bus.i_clear = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_sum   = 6'd7;
    idle(1);
    bus.i_clear = 1'b0;
    bus.i_valid = 1'b0;
    chk("clr_count", int'(bus.o_count), 0);
    chk("clr_acc", int'(bus.o_acc), 0);
    sb.push_back('{8'd4, 1'b0, 3'd4});
    repeat (4) send(6'd1, 1'b0);
    idle(1);

    repeat (3) send(6'd8, 1'b0);
    chk("pre_rst_count", int'(bus.o_count), 3);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_acc", int'(bus.o_acc), 0);
    chk("mid_rst_count", int'(bus.o_count), 0);
    chk("mid_rst_valid", int'(bus.o_valid), 0);
    #2 rstn = 1'b1;
    idle(1);
    sb.push_back('{8'd32, 1'b0, 3'd4});
    repeat (4) send(6'd8, 1'b0);
    idle(1);

    rnd = 1'b1;
    for (int b = 0; b < 100; b++) begin
      int tot;
      logic [5:0] s[4];
      logic c[4];
      tot = 0;
      for (int k = 0; k < 4; k++) begin
        s[k] = 6'($urandom);
        c[k] = 1'($urandom);
        tot += int'({c[k], s[k]});
      end
      sb.push_back('{tot > 255 ? (SAT ? 8'd255 : 8'(tot % 256)) : 8'(tot), tot > 255, 3'd4});
      for (int k = 0; k < 4; k++) begin
        idle($urandom_range(0, 2));
        send(s[k], c[k]);
      end
    end
    for (int n = 0; n < 500 && sb.size() > 0; n++) idle(1);
    chk("drain_empty", sb.size(), 0);
    rnd = 1'b0;
    idle(1);
    bus.i_ready = 1'b1;
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/adder_acc.md
Name: adder_acc

Overview:
- Sequential accumulator directly downstream of the parameterised combinational adder.
- Consumes one {cout, sum} result per accepted transfer and sums NUM_ACC consecutive results.
- Presents the total with a valid/ready output handshake.
- Gives the adder stage a registered, flow-controlled consumer for multi-operand reduction.

Parameters:
- BW_DATA, 6, width of the upstream adder sum (cout is one extra bit).
- NUM_ACC, 4, number of adder results summed per output; legal range >= 1.
- BW_ACC, 8, accumulator and output width; legal range >= BW_DATA+1.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rstn  input  1  asynchronous active-low reset.
- i_sum  input  BW_DATA  upstream adder sum.
- i_cout  input  1  upstream adder carry-out.
- i_valid  input  1  i_sum/i_cout valid this cycle.
- o_ready  output  1  block accepts input this cycle.
- i_clear  input  1  synchronous abort; discard the partial sum.
- o_acc  output  BW_ACC  accumulated result.
- o_ovf  output  1  result overflowed BW_ACC (wrap or saturate event).
- o_count  output  clog2(NUM_ACC+1)  number of words accepted in the current batch.
- o_valid  output  1  o_acc/o_ovf valid.
- i_ready  input  1  downstream accepts the result.

Behaviour:
- Reset: i_rstn low forces, asynchronously, state=IDLE, o_acc=0, o_ovf=0, o_count=0, o_valid=0. o_ready reads 1 because it is decoded from state.
- Input word w = {i_cout, i_sum}, zero-extended to BW_ACC. An input transfer occurs when i_valid && o_ready.
- Each add is acc+w, computed BW_ACC+1 wide; bit BW_ACC is the carry out of the accumulator.
- o_ready = (state != DONE), combinational from state. o_valid = (state == DONE), registered.
- IDLE, on transfer: acc=w, count=1, ovf=0. Next state is DONE if NUM_ACC==1, else ACC.
- ACC, on transfer: acc=acc+w, count+1, and ovf is ORed with the carry. Go to DONE when the accepted word makes count==NUM_ACC.
- ACC, no transfer: all state held; input gaps (bubbles) are legal.
- DONE: o_acc, o_ovf and o_count are held stable, and no input is accepted. On i_ready go to IDLE with o_acc=0, o_ovf=0, o_count=0 in the same edge.
- Latency: o_valid rises on the first clock edge after the last word is accepted. Minimum batch is NUM_ACC cycles plus one DONE cycle.
- Back-to-back batches are not overlapped; one bubble cycle occurs in DONE.
- i_clear=1 has highest priority after reset. From any state it goes to IDLE, clears acc/ovf/count and drops o_valid, and the same-cycle input is not accepted.
- Reset mid-batch discards everything with no partial output.

Optional Feature:
- Macro: ADDER_ACC_SAT_EN.
- Defined: on carry out of BW_ACC, acc saturates to 2^BW_ACC-1 and stays there for the rest of the batch (sat+w stays saturated). o_ovf is set.
- Undefined: acc wraps modulo 2^BW_ACC and o_ovf is sticky-set on any carry.

Decomposition:
- Package adder_acc_pkg holds:
  - State encoding localparams IDLE=2'd0, ACC=2'd1, DONE=2'd2.
  - Width helper for o_count, clog2(NUM_ACC+1).
- Single module; no sub-module is warranted. The next-acc/saturate logic is one always block.

Test Plan (BW_DATA=6, NUM_ACC=4, BW_ACC=8):
- Basic: 4 words sum=10, cout=0, i_valid continuous, i_ready=1. Expect o_valid one cycle after the 4th word, o_acc=40, o_ovf=0, o_count=4.
- Overflow: 4 words sum=63, cout=1 (w=127), total 508.
  - Without macro: o_acc=252, o_ovf=1.
  - With ADDER_ACC_SAT_EN: o_acc=255, o_ovf=1.
- Backpressure and bubbles: words 1,2,3,4 with 2-cycle i_valid gaps, then i_ready held low 5 cycles. Expect o_acc=10 stable, o_ready=0 throughout DONE, and IDLE one cycle after i_ready rises.
- Clear: 2 words (5, 6) accepted, then i_clear with i_valid=1 on word 7, then words 1,1,1,1. Expect word 7 dropped, o_count=0 after the clear, and a final o_acc=4.
- Reset mid-batch: 3 words accepted, i_rstn pulsed low asynchronously between edges. Expect immediate o_acc=0, o_count=0, o_valid=0, and a correct next batch (4×8 gives 32).
- Random: 100 batches of $urandom sum/cout with random i_valid/i_ready. A scoreboard model matches o_acc/o_ovf per batch.
